// File: rtl/decode_stage.sv
// Instruction-decode stage: 4x8 register file with write-through bypass,
// load-use hazard detection and the ID/EXE pipeline register.
module decode_stage #(
    parameter logic [15:0] NOP_INS = 16'h0000,
    parameter logic [3:0]  OP_LOAD = 4'hC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ins_i,
    input  logic        ins_valid_i,
    input  logic        flush_i,
    input  logic        wb_we,
    input  logic [1:0]  wb_addr,
    input  logic [7:0]  wb_data,
    output logic        stall_o,
    output logic [15:0] ex_ins,
    output logic [7:0]  ex_a,
    output logic [7:0]  ex_b,
    output logic        ex_valid
);

    logic [7:0]  rf_q [4];
    logic [7:0]  rf_d [4];

    logic [15:0] ex_ins_q,   ex_ins_d;
    logic [7:0]  ex_a_q,     ex_a_d;
    logic [7:0]  ex_b_q,     ex_b_d;
    logic        ex_valid_q, ex_valid_d;

    logic [1:0]  id_ra, id_rb, ex_dest;
    logic [7:0]  rd_a, rd_b;
    logic        ex_is_load, dest_match;

    assign id_ra   = ins_i[3:2];
    assign id_rb   = ins_i[1:0];
    assign ex_dest = ex_ins_q[3:2];

    // Register-file reads see a same-cycle write-back on the matching index.
    always_comb begin
        rd_a = rf_q[id_ra];
        rd_b = rf_q[id_rb];
        if (wb_we && (wb_addr == id_ra)) rd_a = wb_data;
        if (wb_we && (wb_addr == id_rb)) rd_b = wb_data;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_we) rf_d[wb_addr] = wb_data;
    end

    // Conservative: both source fields compared whatever the ID opcode is.
    assign ex_is_load = (ex_ins_q[7:4] == OP_LOAD);
    assign dest_match = (ex_dest == id_ra) || (ex_dest == id_rb);
    assign stall_o    = ins_valid_i && ex_valid_q && ex_is_load && dest_match && !flush_i;

    always_comb begin
        ex_ins_d   = NOP_INS;
        ex_a_d     = 8'h00;
        ex_b_d     = 8'h00;
        ex_valid_d = 1'b0;
        if (!flush_i && !stall_o) begin
            ex_ins_d   = ins_i;
            ex_a_d     = rd_a;
            ex_b_d     = rd_b;
            ex_valid_d = ins_valid_i;
        end
    end

    // NOTE: the register file is small and architecturally zero after reset,
    // so it is reset with the pipeline register rather than left as RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
            ex_ins_q   <= NOP_INS;
            ex_a_q     <= 8'h00;
            ex_b_q     <= 8'h00;
            ex_valid_q <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            ex_ins_q   <= ex_ins_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign ex_ins   = ex_ins_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_valid = ex_valid_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the SCPU pipeline, directly downstream of the IF/ID stage register and branch control. Holds the 4x8 main register file and reads operands ra/rb for the instruction in IF/ID. Detects load-use hazards against the instruction in EXE and requests a one-cycle stall. Produces the ID/EXE pipeline register, with bubble insertion on stall or flush.

## Interface

Parameters
- `NOP_INS`, 16'h0000: instruction word injected as a bubble.
- `OP_LOAD`, 4'hC: opcode whose result arrives late (load from data memory). Its destination is ra.

Ports
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, **asynchronous, active-low**.
- `ins_i`, in, 16: instruction from IF/ID, with fields [15:8] imm/addr, [7:4] op, [3:2] ra, [1:0] rb.
- `ins_valid_i`, in, 1: `ins_i` holds a real instruction.
- `flush_i`, in, 1: branch taken; discard the instruction currently in ID.
- `wb_we`, in, 1: register-file write enable from WB.
- `wb_addr`, in, 2: write-back destination register.
- `wb_data`, in, 8: write-back value.
- `stall_o`, out, 1: combinational; hold PC and IF/ID this cycle.
- `ex_ins`, out, 16: registered instruction to EXE.
- `ex_a`, out, 8: registered value of R[ra].
- `ex_b`, out, 8: registered value of R[rb].
- `ex_valid`, out, 1: registered; `ex_ins` is a real instruction.

## Operation

- **Register file**
  - R0..R3, 8 bits each. Written on the rising edge when `wb_we`=1.
  - Both reads are combinational with write-through bypass. If `wb_we`=1 and `wb_addr` equals the read index, the read returns `wb_data` in the same cycle.
- **Hazard detect**
  - `stall_o` = `ins_valid_i` & `ex_valid` & (`ex_ins[7:4]`==`OP_LOAD`) & (`ex_ins[3:2]`==`ins_i[3:2]` | `ex_ins[3:2]`==`ins_i[1:0]`) & ~`flush_i`.
  - The comparison is conservative: both fields are compared regardless of the opcode in ID.
- **ID/EXE register update, priority highest first**
  1. `rst`=0: load `NOP_INS`, a=0, b=0, valid=0.
  2. `flush_i`=1: load bubble (`NOP_INS`, 0, 0, valid 0).
  3. `stall_o`=1: load bubble. Upstream holds, so the same instruction is re-decoded next cycle.
  4. Otherwise: load `ins_i`, R[ra], R[rb], and `ins_valid_i`.
- No internal state machine beyond the pipeline register. A stall lasts exactly one cycle, because the bubble removes the LOAD from the hazard window.

## Timing

- **Reset**
  - `ex_ins`=16'h0000, `ex_a`=`ex_b`=0, `ex_valid`=0, all R0..R3=0.
  - Reset takes effect immediately, independent of `clk`.
  - `stall_o` reads 0 during reset.
- **Latency:** one cycle from `ins_i` to `ex_*`.
- **Stall**
  - `stall_o` is valid in the same cycle the hazard exists, before the next edge.
  - Exactly one bubble is inserted per load-use pair.
- **Simultaneous events**
  - Flush and stall together: flush wins, and `stall_o` is forced to 0 so fetch redirects.
  - WB write and read of the same register: the new value is seen. WB writes to R[x] and a hazard stall in the same cycle are independent.
- **Reset mid-stall:** the pipeline register clears. On release, the first edge loads `ins_i` normally.
- **Invalid input:** with `ins_valid_i`=0, `stall_o` stays 0 and the register loads valid=0, with `ex_a`/`ex_b` reflecting whatever the fields index.

## Test plan

1. **Reset:** hold `rst`=0 with `ins_i`=16'h1234 and `ins_valid_i`=1 for 3 edges. Required: `ex_ins`=0, `ex_valid`=0, `stall_o`=0. Reading R0..R3 after release returns 0.
2. **Pass-through and bypass:** write R2=8'h5A via WB. Next cycle present `ins_i`=16'h0019 (op 1, ra=2, rb=1) with `wb_we`=1, `wb_addr`=1, `wb_data`=8'h07. Required after the edge: `ex_a`=8'h5A, `ex_b`=8'h07, `ex_ins`=16'h0019, `ex_valid`=1.
3. **Load-use:** `ex_ins`=16'h40C4 (LOAD, ra=1), then ID `ins_i`=16'h0016 (rb=... ra=1). Required: `stall_o`=1 that cycle and the next `ex_ins`=0, `ex_valid`=0. On the following cycle `stall_o`=0 and `ex_ins`=16'h0016.
4. **No false stall:** `ex_ins`=16'h40CC (LOAD, ra=3) with `ins_i`=16'h0011 (ra=0, rb=1). Required: `stall_o`=0 and no bubble.
5. **Flush beats stall:** set up as in scenario 3 with `flush_i`=1. Required: `stall_o`=0 and the next `ex_ins`=0, `ex_valid`=0.
6. **Async reset mid-operation:** while `ex_valid`=1, drop `rst` between clock edges. Required: outputs clear before the next rising edge.
